// File: rtl/interleaved_burst_reader_if.sv
// interleaved_burst_reader_if: request, output stream and memory port bundle for the burst reader.
interface interleaved_burst_reader_if #(
    parameter int M = 8,
    parameter int K = 11
);
    logic           i_start;
    logic [K-1:0]   i_base_addr;
    logic [K:0]     i_len;
    logic           o_busy;
    logic           o_done;
    logic [M-1:0]   o_out_data;
    logic           o_out_valid;
    logic           i_out_ready;
    logic [K-1:0]   o_mem_A;
    logic           o_mem_WE;
    logic [M-1:0]   o_mem_WD;
    logic [M-1:0]   i_mem_RA;
    logic [2*M-1:0] i_mem_RAdouble;
    modport slave (
        input  i_start, i_base_addr, i_len, i_out_ready, i_mem_RA, i_mem_RAdouble,
        output o_busy, o_done, o_out_data, o_out_valid, o_mem_A, o_mem_WE, o_mem_WD
    );
    modport master (
        output i_start, i_base_addr, i_len, i_out_ready, i_mem_RA, i_mem_RAdouble,
        input  o_busy, o_done, o_out_data, o_out_valid, o_mem_A, o_mem_WE, o_mem_WD
    );
endinterface

// File: rtl/interleaved_burst_reader.sv
// interleaved_burst_reader: burst reader fetching word pairs from even addresses, in-order valid/ready output.
module interleaved_burst_reader #(
    parameter int M = 8,
    parameter int K = 11
) (
    input logic clk,
    input logic rst,
    interleaved_burst_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t       r_state, w_next;
    logic [K-1:0] r_addr, w_addr;
    logic [K:0]   r_rem, w_rem;
    logic [M-1:0] r_data, w_data, r_spare, w_spare;
    logic         r_valid, w_valid, r_spare_valid, w_spare_valid;
    logic         w_slot_free, w_take_spare, w_dbl, w_sgl;
    always_comb begin
        w_slot_free   = !r_valid || bus.i_out_ready;
        w_take_spare  = (r_state == RUN || r_state == FLUSH) && r_spare_valid && w_slot_free;
        w_dbl         = r_state == RUN && !w_take_spare && w_slot_free && !r_addr[0] && r_rem >= (K+1)'(2);
        w_sgl         = r_state == RUN && !w_take_spare && !w_dbl && w_slot_free && r_rem != '0;
        w_next        = r_state;
        w_addr        = r_addr;
        w_rem         = r_rem;
        w_data        = r_data;
        w_spare       = r_spare;
        w_spare_valid = r_spare_valid;
        w_valid       = r_valid && !bus.i_out_ready;
        if (w_take_spare) begin
            w_data        = r_spare;
            w_valid       = 1'b1;
            w_spare_valid = 1'b0;
        end
        // upper half of the double read is the even (lower-address) word
        if (w_dbl) begin
            w_data        = bus.i_mem_RAdouble[2*M-1:M];
            w_spare       = bus.i_mem_RAdouble[M-1:0];
            w_spare_valid = 1'b1;
            w_valid       = 1'b1;
            w_addr        = r_addr + K'(2);
            w_rem         = r_rem - (K+1)'(2);
        end
        if (w_sgl) begin
            w_data  = bus.i_mem_RA;
            w_valid = 1'b1;
            w_addr  = r_addr + K'(1);
            w_rem   = r_rem - (K+1)'(1);
        end
        case (r_state)
            IDLE: if (bus.i_start) begin
                w_next = RUN;
                w_addr = bus.i_base_addr;
                w_rem  = bus.i_len;
            end
            RUN:     if (w_rem == '0) w_next = FLUSH;
            FLUSH:   if (!r_spare_valid && w_slot_free) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            r_data        <= '0;
            r_spare       <= '0;
            r_valid       <= 1'b0;
            r_spare_valid <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_addr        <= w_addr;
            r_rem         <= w_rem;
            r_data        <= w_data;
            r_spare       <= w_spare;
            r_valid       <= w_valid;
            r_spare_valid <= w_spare_valid;
        end
    assign bus.o_busy      = r_state != IDLE;
    assign bus.o_done      = r_state == DONE;
    assign bus.o_out_data  = r_data;
    assign bus.o_out_valid = r_valid;
    assign bus.o_mem_A     = r_state == RUN ? r_addr : '0;
    assign bus.o_mem_WE    = 1'b0;
    assign bus.o_mem_WD    = '0;
endmodule

// File: tb/tb_interleaved_burst_reader.sv
// tb_interleaved_burst_reader: directed and random bursts checked against an address-order reference model.
module tb_interleaved_burst_reader;
    localparam int M = 8;
    localparam int K = 11;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    interleaved_burst_reader_if #(.M(M), .K(K)) bus();
    interleaved_burst_reader #(.M(M), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [M-1:0] mem [0:2**K-1];
    assign bus.i_mem_RA       = mem[bus.o_mem_A];
    assign bus.i_mem_RAdouble = {mem[{bus.o_mem_A[K-1:1], 1'b0}], mem[{bus.o_mem_A[K-1:1], 1'b1}]};
    logic [M-1:0] got[$];
    int           got_cyc[$];
    logic [K-1:0] seen_a[$];
    int done_cnt, done_at, stab_err, valid_cnt, busy0;
    bit timed_out;
    int n_cmp = 0;
    int n_err = 0;
    task automatic run_burst(input logic [K-1:0] b, input logic [K:0] n, input int mode, input bit dup);
        logic pv, pr, rdy;
        logic [M-1:0] pd;
        int stall_left;
        bit fin;
        got.delete(); got_cyc.delete(); seen_a.delete();
        done_cnt = 0; done_at = -1; stab_err = 0; valid_cnt = 0; fin = 0;
        pv = 0; pr = 0; pd = '0; stall_left = -1;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_base_addr = b; bus.i_len = n; bus.i_out_ready = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        busy0 = int'(bus.o_busy);
        for (int c = 0; c < 8000 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (pv && !pr && (bus.o_out_valid !== 1'b1 || bus.o_out_data !== pd)) stab_err++;
            if (bus.o_busy && (seen_a.size() == 0 || seen_a[$] !== bus.o_mem_A)) seen_a.push_back(bus.o_mem_A);
            if (bus.o_done) begin done_cnt++; done_at = c; end
            if (!bus.o_busy) fin = 1;
            else begin
                bus.i_start = dup && c == 2;
                if (dup && c == 2) begin bus.i_base_addr = ~b; bus.i_len = n + 1; end
                rdy = 1'b1;
                if (mode == 1) rdy = $urandom_range(0, 9) < 7;
                if (mode == 2) begin
                    if (stall_left < 0 && bus.o_out_valid) stall_left = 3;
                    rdy = stall_left <= 0;
                    if (stall_left > 0) stall_left--;
                end
                bus.i_out_ready = rdy;
                if (bus.o_out_valid) begin
                    valid_cnt++;
                    if (rdy) begin got.push_back(bus.o_out_data); got_cyc.push_back(c); end
                end
                pv = bus.o_out_valid; pr = rdy; pd = bus.o_out_data;
            end
        end
        timed_out = !fin;
        bus.i_start = 1'b0;
        bus.i_out_ready = 1'b1;
    endtask
    task automatic test_burst(input string nm, input logic [K-1:0] b, input logic [K:0] n, input int mode, input bit dup);
        logic [M-1:0] ew[$];
        logic [K-1:0] er[$];
        logic [K-1:0] a;
        logic [K:0] r;
        bit ok;
        for (int i = 0; i < int'(n); i++) ew.push_back(mem[(int'(b) + i) % (2**K)]);
        a = b; r = n;
        while (r != 0) begin
            if (er.size() == 0 || er[$] !== a) er.push_back(a);
            if (!a[0] && r >= 2) begin a += 2; r -= 2; end
            else begin a += 1; r -= 1; end
        end
        if (er.size() != 0 && er[$] !== '0) er.push_back('0);
        run_burst(b, n, mode, dup);
        n_cmp++;
        if (timed_out) begin
            n_err++;
            $display("FAIL %s timeout: busy still %0b after cycle budget, required 0", nm, bus.o_busy);
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            return;
        end
        n_cmp++;
        if (busy0 !== 1) begin n_err++; $display("FAIL %s busy_rise: got %0d required 1", nm, busy0); end
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL %s done_pulses: got %0d required 1", nm, done_cnt); end
        n_cmp++;
        if (got.size() !== int'(n)) begin n_err++; $display("FAIL %s word_count: got %0d required %0d", nm, got.size(), n); end
        ok = 1;
        for (int i = 0; i < got.size() && i < ew.size(); i++)
            if (ok && got[i] !== ew[i]) begin
                ok = 0;
                $display("FAIL %s word[%0d]: got %02h required %02h", nm, i, got[i], ew[i]);
            end
        n_cmp++;
        if (!ok) n_err++;
        n_cmp++;
        if (stab_err !== 0) begin n_err++; $display("FAIL %s stall_stability: got %0d changes required 0", nm, stab_err); end
        if (n == 0) begin
            n_cmp++;
            if (valid_cnt !== 0) begin n_err++; $display("FAIL %s len0_valid: got %0d valid cycles required 0", nm, valid_cnt); end
        end else begin
            ok = seen_a.size() == er.size();
            for (int i = 0; ok && i < er.size(); i++) if (seen_a[i] !== er[i]) ok = 0;
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL %s read_addrs: got %0d addrs (first %0h) required %0d (first %0h)",
                         nm, seen_a.size(), seen_a.size() ? seen_a[0] : '0, er.size(), er.size() ? er[0] : '0);
            end
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_len = '0; bus.i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b required 0", bus.o_busy); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b required 0", bus.o_done); end
        n_cmp++; if (bus.o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b required 0", bus.o_out_valid); end
        n_cmp++; if (bus.o_out_data !== '0) begin n_err++; $display("FAIL reset out_data: got %h required 0", bus.o_out_data); end
        n_cmp++; if (bus.o_mem_A !== '0) begin n_err++; $display("FAIL reset mem_A: got %h required 0", bus.o_mem_A); end
        n_cmp++; if ({bus.o_mem_WE, bus.o_mem_WD} !== '0) begin n_err++; $display("FAIL reset mem_write: got %h required 0", {bus.o_mem_WE, bus.o_mem_WD}); end
        rst = 1'b0;
    endtask
    task automatic test_aligned();
        test_burst("aligned", 11'd4, 12'd4, 0, 0);
        n_cmp++;
        if (got_cyc.size() != 4 || got_cyc[3] - got_cyc[0] != 3) begin
            n_err++; $display("FAIL aligned back_to_back: got %0d words not on consecutive cycles, required 4 consecutive", got_cyc.size());
        end
        n_cmp++;
        if (got_cyc.size() == 0 || done_at !== got_cyc[$] + 1) begin
            n_err++; $display("FAIL aligned done_timing: got cycle %0d required one after last accept", done_at);
        end
    endtask
    task automatic test_odd_start();
        test_burst("odd_start", 11'd3, 12'd3, 0, 0);
    endtask
    task automatic test_wrap();
        test_burst("wrap", 11'd2047, 12'd3, 0, 0);
    endtask
    task automatic test_stall();
        test_burst("stall", 11'd8, 12'd2, 2, 0);
        n_cmp++;
        if (got_cyc.size() != 2 || got_cyc[0] != 4 || got_cyc[1] != 5) begin
            n_err++; $display("FAIL stall accept_cycles: got %0d words (first at %0d) required 2 at cycles 4,5",
                              got_cyc.size(), got_cyc.size() ? got_cyc[0] : -1);
        end
    endtask
    task automatic test_len0();
        test_burst("len0", 11'd5, 12'd0, 0, 0);
        n_cmp++;
        if (done_at < 0 || done_at > 2) begin n_err++; $display("FAIL len0 done_latency: got %0d required <=2", done_at); end
    endtask
    task automatic test_ignore_start();
        test_burst("ignore_start", 11'd20, 12'd4, 0, 1);
    endtask
    task automatic test_reset_mid();
        int acc;
        acc = 0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_base_addr = 11'd16; bus.i_len = 12'd6; bus.i_out_ready = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge clk);
            if (bus.o_out_valid) acc++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid out_valid: got %b required 0", bus.o_out_valid); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_mid busy: got %b required 0", bus.o_busy); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_mid done: got %b required 0", bus.o_done); end
        @(negedge clk);
        rst = 1'b0;
        test_burst("after_reset", 11'd0, 12'd2, 0, 0);
    endtask
    task automatic test_random();
        logic [K-1:0] b;
        logic [K:0] n;
        for (int i = 0; i < 2**K; i++) mem[i] = M'($urandom);
        for (int i = 0; i < 30; i++) begin
            b = (i % 5 == 0) ? K'(2047 - $urandom_range(0, 3)) : K'($urandom_range(0, 2047));
            n = (i == 0) ? (K+1)'(2048) : (K+1)'($urandom_range(0, 12));
            test_burst("random", b, n, 1, 0);
        end
    endtask
    initial begin
        for (int i = 0; i < 2**K; i++) mem[i] = M'(i);
        test_reset();
        test_aligned();
        test_odd_start();
        test_wrap();
        test_stall();
        test_len0();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/interleaved_burst_reader.md
Name: interleaved_burst_reader

Overview:
Initiator-side controller for the two-module interleaved memory. It accepts a burst request (base address, word count) and drives the memory address port. It fetches two consecutive words per access when the address is even and at least two words remain; otherwise it fetches one word. Words are delivered in address order on a valid/ready output stream with a one-word spare buffer.

Parameters:
M, 8, word width in bits (matches memory cell width)
K, 11, memory address width; capacity 2^K words

Ports:
clock  input  1  single system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  burst request; sampled only in IDLE
base_addr  input  K  first word address of burst
len  input  K+1  number of words, 0..2^K
busy  output  1  high from accepted start until done pulse inclusive
done  output  1  one-cycle pulse when burst fully delivered
out_data  output  M  delivered word
out_valid  output  1  out_data holds an undelivered word
out_ready  input  1  consumer accepts out_data when out_valid & out_ready
mem_A  output  K  address to interleaved memory
mem_WE  output  1  memory write enable; constant 0
mem_WD  output  M  memory write data; constant 0
mem_RA  input  M  single-word read data for mem_A (combinational read)
mem_RAdouble  input  2M  {word at even addr mem_A[K-1:1]&0, word at that addr+1}

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, out_valid=0, out_data=0, mem_A=0, spare_valid=0, internal addr/remaining=0.
- Memory read is combinational: data for mem_A is captured at the same rising edge.
- slot_free = !out_valid | out_ready.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on start, latch addr=base_addr and remaining=len, then go to RUN. start in any other state is ignored. busy rises the cycle after start.
- RUN, evaluated each cycle in priority order:
  1. spare_valid & slot_free: out_data<=spare, out_valid<=1, spare_valid<=0. No memory use.
  2. Else remaining>=2 & addr[0]==0 & slot_free: double read. mem_A=addr; out_data<=mem_RAdouble[2M-1:M] (word addr); spare<=mem_RAdouble[M-1:0] (word addr+1); spare_valid<=1; addr+=2; remaining-=2.
  3. Else remaining>=1 & slot_free: single read. mem_A=addr; out_data<=mem_RA; addr+=1; remaining-=1.
  4. Else if !slot_free: hold; out_data and out_valid stay stable.
  - When remaining reaches 0, go to FLUSH.
- FLUSH: deliver spare (rule 1). When out_valid==0 and spare_valid==0 (or the last word is accepted this cycle with no spare), go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.
- len=0: RUN immediately goes to FLUSH then DONE. No out_valid, no memory access.
- Address arithmetic is modulo 2^K. An odd address 2^K-1 forces a single read, then addr wraps to 0. A double read never spans the wrap, since even addresses pair with addr+1 in the same row.
- out_valid is set in the cycle after the fetch edge. Steady-state throughput with out_ready=1 is one word per cycle. Memory is accessed on at most every other cycle in even-aligned bursts.
- mem_A shows addr whenever state is RUN, including stall cycles; it is 0 in other states.
- Reset mid-burst aborts immediately: no done pulse, the output stream is cleared, and the next start begins a fresh burst.

Test Plan:
- Memory preloaded mem[i]=i[7:0]. base=4, len=4, out_ready=1 -> reads at A=4 (double) then A=6 (double); out_data 0x04,0x05,0x06,0x07 on 4 consecutive cycles; done pulses 1 cycle after 0x07 accepted.
- base=3, len=3 -> single read A=3, then double A=4; out 0x03,0x04,0x05; exactly 2 memory reads.
- base=2047, len=3 -> single A=2047 (out 0xFF), then double A=0 (out 0x00,0x01); mem_A never exceeds 2047.
- base=8, len=2, out_ready held 0 for 3 cycles after first valid -> out_data stays 0x08 with out_valid=1; spare 0x09 follows the cycle after the ready handshake; no extra memory reads.
- len=0 -> done pulse within 3 cycles, out_valid never 1; start pulsed during a len=4 burst is ignored (exactly 4 words out).
- reset asserted after 2 of 6 words -> out_valid, busy, done drop immediately; new start base=0, len=2 yields 0x00,0x01.
